// File: rtl/mem_responder.sv
// Instruction/data memory responder with a boot loader that fills instruction
// memory before releasing the core from reset.
module mem_responder #(
  parameter int unsigned IMEM_AW   = 12,
  parameter int unsigned DMEM_AW   = 12,
  parameter logic [31:0] DMEM_BASE = 32'h1000_0000,
  parameter bit          LOAD_EN   = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] inst_addr_i,
  output logic [31:0] inst_o,
  input  logic        mem_rd_req_i,
  input  logic [31:0] mem_rd_addr_i,
  output logic [31:0] mem_rd_data_o,
  input  logic        mem_wr_req_i,
  input  logic [3:0]  mem_wr_sel_i,
  input  logic [31:0] mem_wr_addr_i,
  input  logic [31:0] mem_wr_data_i,
  input  logic        ld_valid_i,
  input  logic [31:0] ld_data_i,
  input  logic        ld_last_i,
  output logic        ld_ready_o,
  output logic        ld_done_o,
  output logic        core_rst_o,
  output logic        err_o
);

  localparam logic [31:0] NOP        = 32'h0000_0013;
  localparam logic [32:0] DMEM_BYTES = 33'(4) << DMEM_AW;

  typedef enum logic {S_LOAD, S_RUN} state_t;

  state_t               r_state, w_next;
  logic [IMEM_AW-1:0]   r_ld_cnt;
  logic [31:0]          r_rd_data;
  logic                 r_err;
  logic [31:0]          r_imem [0:(1<<IMEM_AW)-1];
  logic [31:0]          r_dmem [0:(1<<DMEM_AW)-1];

  logic                 w_run, w_ld_xfer, w_fetch_oor;
  logic [31:0]          w_rd_off, w_wr_off, w_rd_word;
  logic                 w_rd_oor, w_wr_oor, w_wr_en;
  logic [DMEM_AW-1:0]   w_rd_idx, w_wr_idx;
  logic                 w_unused;

  assign w_run     = (r_state == S_RUN);
  assign w_ld_xfer = !w_run && ld_valid_i;

  // Offsets wrap for addresses below the base, so the explicit compare is redundant but kept clear.
  assign w_rd_off = mem_rd_addr_i - DMEM_BASE;
  assign w_wr_off = mem_wr_addr_i - DMEM_BASE;
  assign w_rd_oor = (mem_rd_addr_i < DMEM_BASE) || ({1'b0, w_rd_off} >= DMEM_BYTES);
  assign w_wr_oor = (mem_wr_addr_i < DMEM_BASE) || ({1'b0, w_wr_off} >= DMEM_BYTES);
  assign w_rd_idx = w_rd_off[DMEM_AW+1:2];
  assign w_wr_idx = w_wr_off[DMEM_AW+1:2];
  assign w_wr_en  = rst && w_run && mem_wr_req_i && !w_wr_oor;

  assign w_unused = ^{inst_addr_i[1:0], w_rd_off[1:0], w_wr_off[1:0]};

  assign w_fetch_oor = |inst_addr_i[31:IMEM_AW+2];
  assign inst_o = (!w_run || w_fetch_oor) ? NOP : r_imem[inst_addr_i[IMEM_AW+1:2]];

  // Read data is write-first: lanes written this cycle override the stored word.
  always_comb begin
    w_rd_word = r_dmem[w_rd_idx];
    if (w_wr_en && (w_wr_idx == w_rd_idx)) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (mem_wr_sel_i[i]) w_rd_word[8*i +: 8] = mem_wr_data_i[8*i +: 8];
      end
    end
  end

  always_comb begin
    w_next = r_state;
    if (w_ld_xfer && (ld_last_i || (r_ld_cnt == '1))) w_next = S_RUN;
  end

  always_ff @(posedge clk) begin
    if (!rst) r_state <= LOAD_EN ? S_LOAD : S_RUN;
    else      r_state <= w_next;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_ld_cnt  <= '0;
      r_rd_data <= '0;
      r_err     <= 1'b0;
    end else begin
      if (w_ld_xfer) r_ld_cnt <= r_ld_cnt + 1'b1;
      if (mem_rd_req_i) r_rd_data <= (w_run && !w_rd_oor) ? w_rd_word : '0;
      if (w_run && ((mem_rd_req_i && w_rd_oor) || (mem_wr_req_i && w_wr_oor)))
        r_err <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst && w_ld_xfer) r_imem[r_ld_cnt] <= ld_data_i;
  end

  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < 4; i++) begin
      if (w_wr_en && mem_wr_sel_i[i]) r_dmem[w_wr_idx][8*i +: 8] <= mem_wr_data_i[8*i +: 8];
    end
  end

  assign mem_rd_data_o = r_rd_data;
  assign err_o         = r_err;
  assign ld_ready_o    = !w_run;
  assign ld_done_o     = w_run;
  assign core_rst_o    = w_run;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: loader, byte-lane writes, write-first reads,
// range errors and mid-load reset.
module tb_mem_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] inst_addr_i;
  logic [31:0] inst_o;
  logic        mem_rd_req_i;
  logic [31:0] mem_rd_addr_i;
  logic [31:0] mem_rd_data_o;
  logic        mem_wr_req_i;
  logic [3:0]  mem_wr_sel_i;
  logic [31:0] mem_wr_addr_i;
  logic [31:0] mem_wr_data_i;
  logic        ld_valid_i;
  logic [31:0] ld_data_i;
  logic        ld_last_i;
  logic        ld_ready_o;
  logic        ld_done_o;
  logic        core_rst_o;
  logic        err_o;

  int errors = 0;
  int checks = 0;

  mem_responder #(.IMEM_AW(12), .DMEM_AW(12), .DMEM_BASE(32'h1000_0000), .LOAD_EN(1'b1)) dut (
    .clk(clk), .rst(rst),
    .inst_addr_i(inst_addr_i), .inst_o(inst_o),
    .mem_rd_req_i(mem_rd_req_i), .mem_rd_addr_i(mem_rd_addr_i), .mem_rd_data_o(mem_rd_data_o),
    .mem_wr_req_i(mem_wr_req_i), .mem_wr_sel_i(mem_wr_sel_i),
    .mem_wr_addr_i(mem_wr_addr_i), .mem_wr_data_i(mem_wr_data_i),
    .ld_valid_i(ld_valid_i), .ld_data_i(ld_data_i), .ld_last_i(ld_last_i),
    .ld_ready_o(ld_ready_o), .ld_done_o(ld_done_o), .core_rst_o(core_rst_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    mem_rd_req_i = 1'b0; mem_wr_req_i = 1'b0; mem_wr_sel_i = 4'h0;
    ld_valid_i = 1'b0; ld_last_i = 1'b0;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    mem_wr_req_i = 1'b1; mem_wr_addr_i = a; mem_wr_data_i = d; mem_wr_sel_i = s;
    tick(); idle();
  endtask

  task automatic rd(input logic [31:0] a);
    mem_rd_req_i = 1'b1; mem_rd_addr_i = a;
    tick(); idle();
  endtask

  task automatic ld(input logic [31:0] d, input logic last);
    ld_valid_i = 1'b1; ld_data_i = d; ld_last_i = last;
    tick(); idle();
  endtask

  initial begin
    rst = 1'b0; inst_addr_i = '0; mem_rd_addr_i = '0; mem_wr_addr_i = '0;
    mem_wr_data_i = '0; ld_data_i = '0;
    idle();
    tick();
    chk("rst_ready", 32'(ld_ready_o), 32'd1);
    chk("rst_done", 32'(ld_done_o), 32'd0);
    chk("rst_core_rst", 32'(core_rst_o), 32'd0);
    chk("rst_err", 32'(err_o), 32'd0);
    chk("rst_rd_data", mem_rd_data_o, 32'h0);
    chk("load_nop", inst_o, 32'h0000_0013);
    rst = 1'b1;

    ld(32'hAAAA_0001, 1'b0);
    ld(32'hAAAA_0002, 1'b0);
    chk("mid_load_done", 32'(ld_done_o), 32'd0);
    ld(32'hAAAA_0003, 1'b1);
    chk("load_done", 32'(ld_done_o), 32'd1);
    chk("load_core_rst", 32'(core_rst_o), 32'd1);
    chk("load_ready", 32'(ld_ready_o), 32'd0);
    inst_addr_i = 32'd8; #1;
    chk("fetch_w2", inst_o, 32'hAAAA_0003);
    inst_addr_i = 32'd1; #1;
    chk("fetch_w0_lowbits", inst_o, 32'hAAAA_0001);
    inst_addr_i = 32'd12; #1;
    checks++;
    assert (inst_o !== 32'h0000_0013) else begin
      errors++;
      $error("FAIL fetch_uninit: observed=%h required=not 00000013", inst_o);
    end
    inst_addr_i = 32'h0000_4000; #1;
    chk("fetch_oor_nop", inst_o, 32'h0000_0013);
    ld(32'h5555_5555, 1'b0);
    inst_addr_i = 32'd12; #1;
    checks++;
    assert (inst_o !== 32'h5555_5555) else begin
      errors++;
      $error("FAIL ld_ignored_in_run: observed=%h required=not 55555555", inst_o);
    end

    wr(32'h1000_0000, 32'hCAFE_F00D, 4'hF);
    wr(32'h1000_0010, 32'h1122_3344, 4'hF);
    wr(32'h1000_0010, 32'hFFFF_FFFF, 4'b0100);
    rd(32'h1000_0010);
    chk("lane_write", mem_rd_data_o, 32'h11FF_3344);
    tick();
    chk("rd_hold", mem_rd_data_o, 32'h11FF_3344);

    wr(32'h1000_0020, 32'h1234_5678, 4'hF);
    mem_wr_req_i = 1'b1; mem_wr_addr_i = 32'h1000_0020; mem_wr_data_i = 32'hDEAD_BEEF;
    mem_wr_sel_i = 4'b0011; mem_rd_req_i = 1'b1; mem_rd_addr_i = 32'h1000_0022;
    tick(); idle();
    chk("write_first", mem_rd_data_o, 32'h1234_BEEF);
    wr(32'h1000_0020, 32'h0000_0000, 4'h0);
    rd(32'h1000_0020);
    chk("sel_zero", mem_rd_data_o, 32'h1234_BEEF);
    wr(32'h1000_3FFC, 32'h7777_8888, 4'hF);
    rd(32'h1000_3FFC);
    chk("top_word", mem_rd_data_o, 32'h7777_8888);
    chk("top_word_err", 32'(err_o), 32'd0);

    rd(32'h0FFF_FFFC);
    chk("oor_rd_data", mem_rd_data_o, 32'h0);
    chk("oor_rd_err", 32'(err_o), 32'd1);
    wr(32'h1000_4000, 32'h0BAD_0BAD, 4'hF);
    chk("oor_wr_err", 32'(err_o), 32'd1);
    rd(32'h1000_4000);
    chk("oor_rd2_data", mem_rd_data_o, 32'h0);
    rd(32'h1000_0000);
    chk("oor_wr_dropped", mem_rd_data_o, 32'hCAFE_F00D);
    chk("err_sticky", 32'(err_o), 32'd1);

    rst = 1'b0; tick(); rst = 1'b1;
    chk("rst2_err", 32'(err_o), 32'd0);
    chk("rst2_core_rst", 32'(core_rst_o), 32'd0);
    chk("rst2_rd_data", mem_rd_data_o, 32'h0);
    ld(32'hB000_0000, 1'b0);
    ld(32'hB000_0001, 1'b0);
    rst = 1'b0; tick(); rst = 1'b1;
    chk("midload_rst_core", 32'(core_rst_o), 32'd0);
    chk("midload_rst_ready", 32'(ld_ready_o), 32'd1);
    wr(32'h1000_0010, 32'h0000_0000, 4'hF);
    rd(32'h0FFF_FFFC);
    chk("load_oor_no_err", 32'(err_o), 32'd0);
    rd(32'h1000_0010);
    chk("load_rd_zero", mem_rd_data_o, 32'h0);
    for (int i = 0; i < 5; i++) ld(32'hC000_0000 + 32'(i), (i == 4));
    chk("reload_done", 32'(ld_done_o), 32'd1);
    for (int i = 0; i < 5; i++) begin
      inst_addr_i = 32'(4 * i); #1;
      chk($sformatf("reload_w%0d", i), inst_o, 32'hC000_0000 + 32'(i));
    end
    rd(32'h1000_0010);
    chk("load_wr_dropped", mem_rd_data_o, 32'h11FF_3344);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
